// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_DVD_W = 8;
  localparam int unsigned DIV_DVS_W = 4;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_DVD_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned DVS_W = 4
) (
  input  logic [DVS_W:0]   i_pr,
  input  logic             i_bit,
  input  logic [DVS_W-1:0] i_dvs,
  output logic [DVS_W:0]   o_pr,
  output logic             o_q
);

  logic [DVS_W:0] w_shifted;
  logic [DVS_W:0] w_dvs_ext;

  assign w_shifted = {i_pr[DVS_W-1:0], i_bit};
  assign w_dvs_ext = {1'b0, i_dvs};

  // A set pr MSB means the shifted value overflows DVS_W+1 bits and must exceed the divisor.
  assign o_q  = i_pr[DVS_W] | (w_shifted >= w_dvs_ext);
  assign o_pr = o_q ? (w_shifted - w_dvs_ext) : w_shifted;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned DVD_W = DIV_DVD_W,
  parameter int unsigned DVS_W = DIV_DVS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(DVD_W);

  state_t           r_state;
  state_t           w_next;
  logic [DVD_W-1:0] r_shift;
  logic [DVS_W:0]   r_pr;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [DVD_W-1:0] r_quotient;
  logic [DVS_W-1:0] r_remainder;
  logic             r_dbz;
  logic [DVS_W:0]   w_pr_next;
  logic             w_q;

  div_step #(.DVS_W(DVS_W)) u_step (
    .i_pr  (r_pr),
    .i_bit (r_shift[DVD_W-1]),
    .i_dvs (r_dvs),
    .o_pr  (w_pr_next),
    .o_q   (w_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Quotient bits enter the shift register LSB as dividend bits leave its MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_pr        <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= '0;
              r_dbz       <= 1'b1;
            end else begin
              r_shift <= dividend;
              r_dvs   <= divisor;
              r_pr    <= '0;
              r_cnt   <= CNT_W'(DVD_W - 1);
            end
          end
        end
        RUN: begin
          r_shift <= {r_shift[DVD_W-2:0], w_q};
          r_pr    <= w_pr_next;
          if (r_cnt == '0) begin
            r_quotient  <= {r_shift[DVD_W-2:0], w_q};
            r_remainder <= w_pr_next[DVS_W-1:0];
            r_dbz       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_checks;
  int n_fail;

  seq_restoring_divider #(.DVD_W(8), .DVS_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start at a falling edge; cycles = falling edges after the start edge until done (-1 on timeout).
  task automatic run_div(input logic [7:0] a, input logic [3:0] b, output int cycles, output logic busy1);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    busy1  = busy;
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (!done) cycles = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b done=%b dbz=%b expected 0 0 0", busy, done, div_by_zero);
    end
    n_checks++;
    if (quotient !== 8'd0 || remainder !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_result: q=%0d r=%0d expected 0 0", quotient, remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int cyc; logic b1;
    run_div(8'd200, 4'd7, cyc, b1);
    n_checks++;
    if (b1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", b1); end
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL basic_latency: got %0d expected 9", cyc); end
    n_checks++;
    if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b expected 28 4 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_boundary;
    logic [7:0] a_t [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [3:0] b_t [4] = '{4'd15, 4'd9, 4'd1, 4'd3};
    logic [7:0] q_t [4] = '{8'd17, 8'd0, 8'd255, 8'd0};
    logic [3:0] r_t [4] = '{4'd0, 4'd5, 4'd0, 4'd0};
    int cyc; logic b1;
    for (int i = 0; i < 4; i++) begin
      run_div(a_t[i], b_t[i], cyc, b1);
      n_checks++;
      if (cyc !== 9 || quotient !== q_t[i] || remainder !== r_t[i]) begin
        n_fail++;
        $display("FAIL boundary_%0d: cyc=%0d q=%0d r=%0d expected 9 %0d %0d", i, cyc, quotient, remainder, q_t[i], r_t[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int cyc; logic b1;
    run_div(8'd77, 4'd0, cyc, b1);
    n_checks++;
    if (cyc !== 1 || b1 !== 1'b1) begin
      n_fail++; $display("FAIL dz_latency: cyc=%0d busy=%b expected 1 1", cyc, b1);
    end
    n_checks++;
    if (quotient !== 8'hFF || remainder !== 4'd0 || div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_result: q=%0d r=%0d dbz=%b expected 255 0 1", quotient, remainder, div_by_zero);
    end
    run_div(8'd9, 4'd3, cyc, b1);
    n_checks++;
    if (cyc !== 9 || quotient !== 8'd3 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_recover: cyc=%0d q=%0d r=%0d dbz=%b expected 9 3 0 0", cyc, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_start;
    int dones; int done_cyc;
    @(negedge clk);
    dividend = 8'd100; divisor = 4'd6; start = 1'b1;
    dones = 0; done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin dones++; if (done_cyc < 0) done_cyc = c; end
      if (c == 3 || c == 9) begin dividend = 8'd50; divisor = 4'd5; start = 1'b1; end
    end
    n_checks++;
    if (dones !== 1 || done_cyc !== 9) begin
      n_fail++; $display("FAIL ignore_done: pulses=%0d at=%0d expected 1 9", dones, done_cyc);
    end
    n_checks++;
    if (quotient !== 8'd16 || remainder !== 4'd4) begin
      n_fail++; $display("FAIL ignore_result: q=%0d r=%0d expected 16 4", quotient, remainder);
    end
  endtask

  task automatic test_reset_abort;
    int dones; int cyc; logic b1;
    @(negedge clk);
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: busy=%b done=%b q=%0d r=%0d dbz=%b expected all 0", busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: active cycles=%0d expected 0", dones); end
    run_div(8'd13, 4'd4, cyc, b1);
    n_checks++;
    if (cyc !== 9 || quotient !== 8'd3 || remainder !== 4'd1) begin
      n_fail++; $display("FAIL abort_recover: cyc=%0d q=%0d r=%0d expected 9 3 1", cyc, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int a; int b; int gap; int waited; int eq; int er; bit first; int bad;
    a = 0; b = 1; first = 1'b1; gap = 0; bad = 0;
    @(negedge clk);
    dividend = 8'(a); divisor = 4'(b); start = 1'b1;
    while (a < 256) begin
      waited = 0;
      do begin @(negedge clk); waited++; gap++; end while (!done && waited < 30);
      if (!done) begin
        n_checks++; n_fail++;
        $display("FAIL sweep_timeout: no done for %0d/%0d", a, b);
        start = 1'b0;
        return;
      end
      eq = a / b;
      er = a % b;
      n_checks++;
      if (quotient !== 8'(eq) || remainder !== 4'(er) || div_by_zero !== 1'b0) begin
        n_fail++;
        if (bad < 10) $display("FAIL sweep_result: %0d/%0d q=%0d r=%0d expected %0d %0d", a, b, quotient, remainder, eq, er);
        bad++;
      end
      if (!first) begin
        n_checks++;
        if (gap !== 10) begin
          n_fail++;
          if (bad < 10) $display("FAIL sweep_spacing: %0d/%0d gap=%0d expected 10", a, b, gap);
          bad++;
        end
      end
      first = 1'b0;
      gap = 0;
      if (b < 15) b++;
      else begin b = 1; a++; end
      if (a < 256) begin dividend = 8'(a); divisor = 4'(b); end
      else start = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the MAC datapath: it takes an 8-bit value, such as the MAC accumulator, and divides it by a 4-bit operand using repeated shift and subtract.
- Resolves one quotient bit per clock, MSB first.
- Uses a start/busy/done handshake so a controller can sequence it alongside the MAC.
- Serves the TinyTapeout wrapper as a second arithmetic mode (averaging/normalising accumulated sums).

Parameters:
DVD_W, 8, dividend and quotient width.
DVS_W, 4, divisor and remainder width; must satisfy DVS_W <= DVD_W.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE.
dividend  input  DVD_W  numerator; captured on the accepted start edge.
divisor  input  DVS_W  denominator; captured on the accepted start edge.
busy  output  1  high in RUN and DONE states.
done  output  1  single-cycle completion pulse.
quotient  output  DVD_W  registered result; holds until the next completion.
remainder  output  DVS_W  registered result; holds until the next completion.
div_by_zero  output  1  registered flag, updated at each completion.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = done = div_by_zero = 0.
  - quotient = 0, remainder = 0.
  - Internal shift, partial-remainder and count registers = 0.
  - Reset mid-operation aborts the divide; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1, divisor != 0:
  - Capture dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (DVS_W+1 bits).
  - Set cnt = DVD_W-1.
  - Next state RUN.
- IDLE, start=1, divisor == 0:
  - Next state DONE directly.
  - At that edge load quotient = all-ones, remainder = 0, div_by_zero = 1.
- RUN, one step per cycle:
  - pr' = {pr[DVS_W-1:0], shift MSB}; shift register shifts left.
  - If pr' >= {0, divisor}: pr = pr' - divisor and the q bit = 1; otherwise pr = pr' and the q bit = 0.
  - The q bit enters the shift register LSB, so quotient and dividend share one register.
  - When cnt == 0, next state DONE and load quotient/remainder from the final step; div_by_zero = 0. Otherwise decrement cnt.
- DONE: done = 1 for exactly one cycle, busy = 1; next state IDLE.
- Latency:
  - Normal divide: done is high during the (DVD_W+1)th cycle after the start edge, i.e. 9 cycles at defaults.
  - Divide by zero: done is high the cycle after the start edge.
- start in RUN or DONE is ignored; no queueing. Back-to-back throughput is one divide per DVD_W+2 cycles.
- Operands are captured, so the dividend/divisor inputs may change freely while busy.
- Remainder is always < divisor, so it fits in DVS_W bits; the pr MSB exists only for the compare.
- Outputs are fully registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (div_pkg):
  - state enum {IDLE, RUN, DONE}.
  - Default width constants DVD_W=8, DVS_W=4.
  - Counter width constant $clog2(DVD_W).
- One sub-module: div_step. It is combinational and implements one restoring step:
  - Inputs: pr, next dividend bit, divisor.
  - Outputs: new pr, q bit.
  - Keeping it separate allows later unrolling to 2 bits per cycle.
- The FSM, counter and registers stay in seq_restoring_divider.

Test Plan:
1. Reset, then start with dividend=200, divisor=7 -> busy is high the next cycle; done pulses at cycle 9; quotient=28, remainder=4, div_by_zero=0.
2. Boundary operands: 255/15 -> q=17, r=0. 5/9 -> q=0, r=5. 255/1 -> q=255, r=0. 0/3 -> q=0, r=0.
3. divisor=0, dividend=77 -> done pulses on cycle 1 after start; q=8'hFF, r=0, div_by_zero=1. A following 9/3 -> q=3, r=0, div_by_zero=0.
4. Start 100/6, then pulse start with 50/5 on cycles 3 and 9 (the DONE cycle) -> both are ignored; result q=16, r=4; exactly one done pulse.
5. Start 200/7, drop rst_n at cycle 4 -> all outputs are 0 immediately (asynchronously); no done pulse. After release, 13/4 -> q=3, r=1.
6. Random sweep of all 256x15 non-zero operand pairs, back-to-back with start asserted in each IDLE cycle -> q/r match a reference model; done spacing is exactly 10 cycles.
